// File: rtl/uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_responder
// Purpose  : Decodes single-character UART commands into control pulses.
//            It sends an ASCII reply to each command, and the 'D' command
//            replies with the humidity and temperature as decimal text.
//            The optional macro RESP_ERR_COUNT_EN adds the err_count output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_responder #(
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic [7:0] humidity,
    input  logic [7:0] temperature,
    output logic       cmd_run,
    output logic       cmd_stop,
    output logic       cmd_clear,
    output logic       cmd_mode,
`ifdef RESP_ERR_COUNT_EN
    output logic [7:0] err_count,
`endif
    output logic       resp_busy
);

    localparam int c_TMO_W = $clog2(BUSY_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_idx;
    logic [7:0]         r_letter;
    logic               r_is_d;
    logic [7:0]         r_hum;
    logic [7:0]         r_temp;
    logic [c_TMO_W-1:0] r_tmo;

    logic [7:0] w_upper;
    logic       w_is_cmd;
    logic       w_is_d;
    logic       w_accept;
    logic       w_last;
    logic       w_tmo_done;
    logic [7:0] w_byte;

    assign w_upper    = (rx_data >= "a" && rx_data <= "z") ? rx_data - 8'h20 : rx_data;
    assign w_is_cmd   = (w_upper == "R") || (w_upper == "S") || (w_upper == "C") || (w_upper == "M");
    assign w_is_d     = (w_upper == "D");
    assign w_accept   = rx_done && (r_state == ST_IDLE);
    assign w_last     = r_is_d ? (r_idx == 3'd7) : (r_idx == 3'd2);
    assign w_tmo_done = (r_tmo == c_TMO_W'(BUSY_TIMEOUT - 1));
    assign resp_busy  = (r_state != ST_IDLE);

    // Response byte for the current index; sensor values are already clamped to 0..99
    always_comb begin
        w_byte = 8'h0A;
        if (r_is_d) begin
            case (r_idx)
                3'd0:    w_byte = "H";
                3'd1:    w_byte = 8'h30 + (r_hum / 8'd10);
                3'd2:    w_byte = 8'h30 + (r_hum % 8'd10);
                3'd3:    w_byte = "T";
                3'd4:    w_byte = 8'h30 + (r_temp / 8'd10);
                3'd5:    w_byte = 8'h30 + (r_temp % 8'd10);
                3'd6:    w_byte = 8'h0D;
                default: w_byte = 8'h0A;
            endcase
        end else begin
            case (r_idx)
                3'd0:    w_byte = r_letter;
                3'd1:    w_byte = 8'h0D;
                default: w_byte = 8'h0A;
            endcase
        end
    end

    always_comb begin
        w_next   = r_state;
        tx_start = 1'b0;
        case (r_state)
            ST_IDLE:      if (rx_done) w_next = ST_LOAD;
            ST_LOAD:      w_next = ST_SEND;
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    w_next   = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (tx_busy)         w_next = ST_WAIT_DONE;
                else if (w_tmo_done) w_next = ST_IDLE;
            end
            ST_WAIT_DONE: if (!tx_busy) w_next = w_last ? ST_IDLE : ST_LOAD;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= 3'd0;
            r_letter  <= 8'h00;
            r_is_d    <= 1'b0;
            r_hum     <= 8'h00;
            r_temp    <= 8'h00;
            r_tmo     <= '0;
            tx_data   <= 8'h00;
            cmd_run   <= 1'b0;
            cmd_stop  <= 1'b0;
            cmd_clear <= 1'b0;
            cmd_mode  <= 1'b0;
        end else begin
            r_state   <= w_next;
            cmd_run   <= w_accept && (w_upper == "R");
            cmd_stop  <= w_accept && (w_upper == "S");
            cmd_clear <= w_accept && (w_upper == "C");
            cmd_mode  <= w_accept && (w_upper == "M");
            if (w_accept) begin
                r_letter <= w_is_cmd ? w_upper : "?";
                r_is_d   <= w_is_d;
                r_hum    <= (humidity > 8'd99) ? 8'd99 : humidity;
                r_temp   <= (temperature > 8'd99) ? 8'd99 : temperature;
            end
            if (r_state == ST_LOAD) tx_data <= w_byte;
            r_tmo <= (r_state == ST_WAIT_BUSY) ? r_tmo + 1'b1 : '0;
            if (r_state == ST_WAIT_BUSY && w_next == ST_IDLE) begin
                r_idx <= 3'd0;
            end else if (r_state == ST_WAIT_DONE && !tx_busy) begin
                r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
            end
        end
    end

`ifdef RESP_ERR_COUNT_EN
    logic [7:0] r_err;
    assign err_count = r_err;

    // Invalid commands and bytes dropped while busy both count, saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 8'h00;
        end else if (((w_accept && !w_is_cmd && !w_is_d) || (rx_done && r_state != ST_IDLE))
                     && r_err != 8'hFF) begin
            r_err <= r_err + 8'h01;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
`default_nettype none
// Directed bench for uart_cmd_responder with a simple transmitter model.
module tb_uart_cmd_responder;

    localparam int BUSY_CYC = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_busy = 1'b0;
    logic [7:0] humidity = 8'h00;
    logic [7:0] temperature = 8'h00;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       cmd_run, cmd_stop, cmd_clear, cmd_mode, resp_busy;
`ifdef RESP_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    uart_cmd_responder #(.BUSY_TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .humidity    (humidity),
        .temperature (temperature),
        .cmd_run     (cmd_run),
        .cmd_stop    (cmd_stop),
        .cmd_clear   (cmd_clear),
        .cmd_mode    (cmd_mode),
`ifdef RESP_ERR_COUNT_EN
        .err_count   (err_count),
`endif
        .resp_busy   (resp_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int n_run, n_stop, n_clear, n_mode, run_cyc, rx_cyc, start_cnt, start_busy;
    logic model_en = 1'b1;
    logic [7:0] cap_q[$];
    logic [7:0] exp_b[8];

    // Pulse and protocol monitor
    initial forever begin
        @(negedge clk);
        if (tx_start && tx_busy) start_busy++;
        if (cmd_run) begin
            if (n_run == 0) run_cyc = cyc;
            n_run++;
        end
        if (cmd_stop)  n_stop++;
        if (cmd_clear) n_clear++;
        if (cmd_mode)  n_mode++;
    end

    // Transmitter model: busy rises the cycle after start, stays high BUSY_CYC cycles
    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            cap_q.push_back(tx_data);
            start_cnt++;
            if (model_en) begin
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (BUSY_CYC) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    task automatic clear_mon();
        n_run = 0; n_stop = 0; n_clear = 0; n_mode = 0;
        run_cyc = -1; start_cnt = 0; start_busy = 0;
        cap_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clear_mon();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        rx_cyc  = cyc;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (resp_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (resp_busy) begin
            checks++; failures++;
            $display("FAIL wait_idle: resp_busy still %0b after %0d cycles, required 0", resp_busy, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start: got %0b want 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if ({cmd_run, cmd_stop, cmd_clear, cmd_mode} !== 4'b0000) begin
            failures++; $display("FAIL reset_cmds: got %b want 0000", {cmd_run, cmd_stop, cmd_clear, cmd_mode});
        end
        checks++; if (resp_busy !== 1'b0) begin failures++; $display("FAIL reset_resp_busy: got %0b want 0", resp_busy); end
`ifdef RESP_ERR_COUNT_EN
        checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
`endif
        @(negedge clk);
        reset = 1'b1;
        clear_mon();
    endtask

    task automatic test_run();
        apply_reset();
        send_byte(8'h72);
        checks++; if (resp_busy !== 1'b1) begin failures++; $display("FAIL run_resp_busy: got %0b want 1", resp_busy); end
        wait_idle();
        exp_b[0] = 8'h52; exp_b[1] = 8'h0D; exp_b[2] = 8'h0A;
        checks++; if (cap_q.size() != 3) begin failures++; $display("FAIL run_len: got %0d want 3", cap_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cap_q.size() <= i || cap_q[i] !== exp_b[i]) begin
                failures++; $display("FAIL run_byte%0d: got %h want %h", i, (cap_q.size() > i) ? cap_q[i] : 8'hxx, exp_b[i]);
            end
        end
        checks++; if (n_run != 1) begin failures++; $display("FAIL run_pulse_width: got %0d want 1", n_run); end
        checks++; if (run_cyc != rx_cyc + 1) begin failures++; $display("FAIL run_pulse_cycle: got %0d want %0d", run_cyc, rx_cyc + 1); end
        checks++; if (n_stop + n_clear + n_mode != 0) begin failures++; $display("FAIL run_other_pulses: got %0d want 0", n_stop + n_clear + n_mode); end
        checks++; if (start_busy != 0) begin failures++; $display("FAIL run_start_while_busy: got %0d want 0", start_busy); end
    endtask

    task automatic test_sensor(input logic [7:0] cmd, input logic [7:0] h, input logic [7:0] t,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3);
        apply_reset();
        humidity = h; temperature = t;
        send_byte(cmd);
        humidity = 8'd0; temperature = 8'd0;
        wait_idle();
        exp_b[0] = 8'h48; exp_b[1] = d0; exp_b[2] = d1; exp_b[3] = 8'h54;
        exp_b[4] = d2;    exp_b[5] = d3; exp_b[6] = 8'h0D; exp_b[7] = 8'h0A;
        checks++; if (cap_q.size() != 8) begin failures++; $display("FAIL sensor_len: got %0d want 8", cap_q.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap_q.size() <= i || cap_q[i] !== exp_b[i]) begin
                failures++; $display("FAIL sensor_byte%0d: got %h want %h", i, (cap_q.size() > i) ? cap_q[i] : 8'hxx, exp_b[i]);
            end
        end
        checks++; if (n_run + n_stop + n_clear + n_mode != 0) begin
            failures++; $display("FAIL sensor_pulses: got %0d want 0", n_run + n_stop + n_clear + n_mode);
        end
    endtask

    task automatic test_invalid();
        apply_reset();
        send_byte(8'h41);
        wait_idle();
        exp_b[0] = 8'h3F; exp_b[1] = 8'h0D; exp_b[2] = 8'h0A;
        checks++; if (cap_q.size() != 3) begin failures++; $display("FAIL inv_len: got %0d want 3", cap_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cap_q.size() <= i || cap_q[i] !== exp_b[i]) begin
                failures++; $display("FAIL inv_byte%0d: got %h want %h", i, (cap_q.size() > i) ? cap_q[i] : 8'hxx, exp_b[i]);
            end
        end
        checks++; if (n_run + n_stop + n_clear + n_mode != 0) begin
            failures++; $display("FAIL inv_pulses: got %0d want 0", n_run + n_stop + n_clear + n_mode);
        end
`ifdef RESP_ERR_COUNT_EN
        checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL inv_err_count: got %0d want 1", err_count); end
`endif
    endtask

    task automatic test_drop_while_busy();
        int n;
        apply_reset();
        send_byte(8'h53);
        n = 0;
        while (start_cnt < 1 && n < 100) begin @(negedge clk); n++; end
        send_byte(8'h43);
        wait_idle();
        exp_b[0] = 8'h53; exp_b[1] = 8'h0D; exp_b[2] = 8'h0A;
        checks++; if (cap_q.size() != 3) begin failures++; $display("FAIL drop_len: got %0d want 3", cap_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cap_q.size() <= i || cap_q[i] !== exp_b[i]) begin
                failures++; $display("FAIL drop_byte%0d: got %h want %h", i, (cap_q.size() > i) ? cap_q[i] : 8'hxx, exp_b[i]);
            end
        end
        checks++; if (n_stop != 1) begin failures++; $display("FAIL drop_stop_pulse: got %0d want 1", n_stop); end
        checks++; if (n_clear != 0) begin failures++; $display("FAIL drop_clear_pulse: got %0d want 0", n_clear); end
`ifdef RESP_ERR_COUNT_EN
        checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL drop_err_count: got %0d want 1", err_count); end
`endif
    endtask

    task automatic test_timeout_and_reset();
        int n;
        int busy_cycles;
        apply_reset();
        model_en = 1'b0;
        send_byte(8'h6D);
        n = 0;
        while (!tx_start && n < 20) begin @(negedge clk); n++; end
        checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL tmo_start: got %0b want 1", tx_start); end
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!resp_busy) break;
            busy_cycles++;
        end
        checks++; if (busy_cycles != 16) begin failures++; $display("FAIL tmo_wait_cycles: got %0d want 16", busy_cycles); end
        checks++; if (resp_busy !== 1'b0) begin failures++; $display("FAIL tmo_resp_busy: got %0b want 0", resp_busy); end
        checks++; if (tx_data !== 8'h4D) begin failures++; $display("FAIL tmo_tx_data: got %h want 4d", tx_data); end
        checks++; if (n_mode != 1) begin failures++; $display("FAIL tmo_mode_pulse: got %0d want 1", n_mode); end
        checks++; if (start_cnt != 1) begin failures++; $display("FAIL tmo_start_count: got %0d want 1", start_cnt); end
        model_en = 1'b1;

        // Reset in the middle of a 'D' response
        clear_mon();
        humidity = 8'd45; temperature = 8'd23;
        send_byte(8'h44);
        n = 0;
        while (start_cnt < 2 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (resp_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_resp_busy: got %0b want 0", resp_busy); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_mid_tx_data: got %h want 00", tx_data); end
        checks++; if ({tx_start, cmd_run, cmd_stop, cmd_clear, cmd_mode} !== 5'b0) begin
            failures++; $display("FAIL rst_mid_outputs: got %b want 00000", {tx_start, cmd_run, cmd_stop, cmd_clear, cmd_mode});
        end
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        while (tx_busy && n < 50) begin @(negedge clk); n++; end
        clear_mon();
        send_byte(8'h52);
        wait_idle();
        exp_b[0] = 8'h52; exp_b[1] = 8'h0D; exp_b[2] = 8'h0A;
        checks++; if (cap_q.size() != 3) begin failures++; $display("FAIL post_rst_len: got %0d want 3", cap_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cap_q.size() <= i || cap_q[i] !== exp_b[i]) begin
                failures++; $display("FAIL post_rst_byte%0d: got %h want %h", i, (cap_q.size() > i) ? cap_q[i] : 8'hxx, exp_b[i]);
            end
        end
        checks++; if (n_run != 1) begin failures++; $display("FAIL post_rst_run_pulse: got %0d want 1", n_run); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_run();
        test_sensor(8'h44, 8'd45, 8'd23, 8'h34, 8'h35, 8'h32, 8'h33);
        test_sensor(8'h64, 8'd150, 8'd7, 8'h39, 8'h39, 8'h30, 8'h37);
        test_invalid();
        test_drop_while_busy();
        test_timeout_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
